ripple_cnt_sampler: RTL and testbench
=====================================

Name: ripple_cnt_sampler

Overview:
- Downstream consumer of the n-bit asynchronous (ripple) up/down counter.
- Samples the counter's glitchy, unsynchronised output into the system clock domain and accepts a value only when it is stable.
- Extends the count with a wrap counter and presents each new value on a valid/ready interface to the next stage.
- Optionally checks that every accepted step is a legal ±1 step.

Parameters:
N, 4, width of ripple counter value (must match the upstream counter's n)
EXT, 4, width of wrap-extension count (upper bits of the extended value)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
cnt_in  input  N  raw ripple counter output, asynchronous to clk
mode  input  1  count direction of upstream counter: 1 = up, 0 = down; quasi-static, asynchronous
ready  input  1  downstream accepts current value
cnt_q  output  N  last accepted stable counter value
ext_q  output  EXT  wrap count, modulo 2^EXT
valid  output  1  new value pending on cnt_q/ext_q
wrap_up  output  1  one-cycle pulse, up-wrap accepted
wrap_dn  output  1  one-cycle pulse, down-wrap accepted
drop  output  1  one-cycle pulse, pending value overwritten before ready
err  output  1  sticky illegal-step flag (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs and internal registers go to 0; FSM enters INIT.
  - Release is synchronous to clk via the normal register path; no reset synchroniser inside this block.
- Synchronisation:
  - cnt_in passes through two flops, s1 then s2; s3 holds the previous s2.
  - mode passes through two flops to give mode_s.
- Stability: stable = (s2 == s3). A value that is never equal in two consecutive s2 samples is never accepted.
- Latency: a cnt_in change held steady is reflected on cnt_q at the 4th rising edge after the first edge that samples it.
- FSM states: INIT, TRACK.
  - INIT: at the first edge with stable=1:
    - cnt_q <= s2 and valid <= 1.
    - No wrap pulse, no error check; go to TRACK.
  - TRACK: an update occurs at an edge where stable=1 and s2 != cnt_q. On an update:
    - cnt_q <= s2.
    - If mode_s=1, cnt_q == 2^N-1 and s2 == 0: ext_q <= ext_q+1 and wrap_up pulses.
    - If mode_s=0, cnt_q == 0 and s2 == 2^N-1: ext_q <= ext_q-1 and wrap_dn pulses.
    - ext_q wraps modulo 2^EXT silently.
- Handshake:
  - valid rises at an update edge and stays high until an edge with ready=1 and no update, then clears.
  - Update and ready at the same edge: the old value is consumed and the new one is loaded; valid stays 1, no drop.
  - Update while valid=1 and ready=0: the newest value replaces the pending one (latest-value semantics) and drop pulses for one cycle.
  - ready while valid=0 is ignored.
- Mode change: takes effect 2 edges after it is applied. An update in the same cycle uses mode_s, i.e. the synchronised value.
- Reset mid-operation: immediate clear. After release the block behaves as from power-up, and INIT reloads without a wrap check.
- Pulses (wrap_up, wrap_dn, drop) are registered and high for exactly one cycle.

Optional Feature:
Macro RIPPLE_STEP_CHECK_EN.
- Defined: on every TRACK update, the expected value is cnt_q+1 (mode_s=1) or cnt_q-1 (mode_s=0), modulo 2^N. If s2 differs from it:
  - err is set and stays 1 until reset.
  - The value is still accepted.
  - The wrap rule is evaluated normally.
- Not defined: err is tied 0 and no step-compare logic is built. The port list is identical.

Decomposition:
- Package ripple_cnt_pkg holds:
  - state encoding constants ST_INIT=1'b0, ST_TRACK=1'b1;
  - direction constants DIR_UP=1'b1, DIR_DN=1'b0.
- One sub-module: sync2, a parameterised-width two-flop synchroniser with the same clk/rst, used for cnt_in and for mode.
- Wrap, handshake and step-check logic stay in ripple_cnt_sampler.

Test Plan:
- Reset and first sample: N=4, cnt_in=5 held, release rst → cnt_q=5 and valid=1 at the 4th edge; ext_q=0; no pulses.
- Up wrap: mode=1, ready=1, step cnt_in 14→15→0 with 8 cycles per step → ext_q 0→1; wrap_up one cycle, coincident with cnt_q=0.
- Down wrap: mode=0, cnt_in 1→0→15 → ext_q decrements 1→0xF-style modulo (0→15); wrap_dn one pulse.
- Glitch rejection: toggle cnt_in 6→7→6 changing every clock for 6 cycles, then hold 7 → no update during the toggling; a single update to 7 after the hold.
- Backpressure: ready=0, two updates 3→4→5 → valid stays 1, drop pulses once, cnt_q=5; then ready=1 for one edge → valid clears.
- Step check (macro defined): mode=1, cnt_q=2, cnt_in jumps to 9 → cnt_q=9 and err=1, remaining 1 until rst=0; without the macro, err stays 0.

Source files
------------

// File: rtl/ripple_cnt_pkg.sv
// ripple_cnt_pkg: shared FSM state and count-direction encodings for ripple_cnt_sampler.
package ripple_cnt_pkg;
  typedef enum logic {ST_INIT = 1'b0, ST_TRACK = 1'b1} state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
endpackage

// File: rtl/ripple_cnt_sampler_sync2.sv
// sync2: parameterised-width two-flop synchroniser, async active-low reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
endmodule

// File: rtl/ripple_cnt_sampler.sv
// ripple_cnt_sampler: stable-sample a ripple counter, extend with wrap count, valid/ready output.
// Define RIPPLE_STEP_CHECK_EN to build the sticky illegal-step flag on err.
module ripple_cnt_sampler
  import ripple_cnt_pkg::*;
#(
  parameter int N   = 4,
  parameter int EXT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   cnt_in,
  input  logic           mode,
  input  logic           ready,
  output logic [N-1:0]   cnt_q,
  output logic [EXT-1:0] ext_q,
  output logic           valid,
  output logic           wrap_up,
  output logic           wrap_dn,
  output logic           drop,
  output logic           err
);
  logic [N-1:0] s2, s3;
  logic         mode_s, stable, upd, wu, wd;
  logic [1:0]   fill;
  state_t       state;
  sync2 #(.W(N)) u_cnt  (.clk(clk), .rst(rst), .d(cnt_in), .q(s2));
  sync2 #(.W(1)) u_mode (.clk(clk), .rst(rst), .d(mode),   .q(mode_s));
  assign stable = (s2 == s3);
  assign upd    = (state == ST_TRACK) && stable && (s2 != cnt_q);
  assign wu     = upd && (mode_s == DIR_UP) && (cnt_q == '1) && (s2 == '0);
  assign wd     = upd && (mode_s == DIR_DN) && (cnt_q == '0) && (s2 == '1);
  // fill keeps INIT from accepting the reset zeros before s3 holds a real sample
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s3      <= '0;
      fill    <= '0;
      state   <= ST_INIT;
      cnt_q   <= '0;
      ext_q   <= '0;
      valid   <= 1'b0;
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
      drop    <= 1'b0;
    end else begin
      s3      <= s2;
      wrap_up <= wu;
      wrap_dn <= wd;
      drop    <= upd && valid && !ready;
      if (state == ST_INIT) begin
        if (fill != 2'd3) fill <= fill + 2'd1;
        else if (stable) begin
          cnt_q <= s2;
          valid <= 1'b1;
          state <= ST_TRACK;
        end
      end else begin
        if (upd) cnt_q <= s2;
        valid <= upd || (valid && !ready);
        ext_q <= wu ? ext_q + 1'b1 : wd ? ext_q - 1'b1 : ext_q;
      end
    end
`ifdef RIPPLE_STEP_CHECK_EN
  logic [N-1:0] nxt;
  assign nxt = (mode_s == DIR_UP) ? cnt_q + 1'b1 : cnt_q - 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) err <= 1'b0;
    else if (upd && (s2 != nxt)) err <= 1'b1;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ripple_cnt_sampler.sv
// tb_ripple_cnt_sampler: directed self-checking bench for ripple_cnt_sampler.
module tb_ripple_cnt_sampler;
`ifdef RIPPLE_STEP_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst, mode, ready;
  logic [3:0] cnt_in, cnt_q, ext_q;
  logic       valid, wrap_up, wrap_dn, drop, err;
  int         total = 0, bad = 0, nv;
  ripple_cnt_sampler #(.N(4), .EXT(4)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .mode(mode), .ready(ready),
    .cnt_q(cnt_q), .ext_q(ext_q), .valid(valid), .wrap_up(wrap_up),
    .wrap_dn(wrap_dn), .drop(drop), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [3:0] v);
    cnt_in = v;
    tick(8);
  endtask
  initial begin
    rst = 1'b0; mode = 1'b1; ready = 1'b0; cnt_in = 4'd5;
    #23;
    chk("rst_cnt", cnt_q, 0); chk("rst_valid", valid, 0); chk("rst_ext", ext_q, 0);
    rst = 1'b1;
    tick(3);
    chk("init_edge3_valid", valid, 0);
    chk("init_edge3_cnt", cnt_q, 0);
    tick(1);
    chk("init_cnt", cnt_q, 5); chk("init_valid", valid, 1); chk("init_ext", ext_q, 0);
    chk("init_pulses", {wrap_up, wrap_dn, drop}, 0);
    ready = 1'b1;
    tick(1);
    chk("ready_clear", valid, 0);
    tick(3);
    for (int v = 6; v <= 14; v++) step(4'(v));
    chk("up_14", cnt_q, 14);
    step(4'd15);
    chk("up_15", cnt_q, 15);
    cnt_in = 4'd0;
    tick(3);
    chk("upwrap_pre_cnt", cnt_q, 15); chk("upwrap_pre_pulse", wrap_up, 0);
    tick(1);
    chk("upwrap_cnt", cnt_q, 0); chk("upwrap_ext", ext_q, 1);
    chk("upwrap_pulse", wrap_up, 1); chk("upwrap_valid", valid, 1);
    tick(1);
    chk("upwrap_pulse_end", wrap_up, 0); chk("upwrap_valid_end", valid, 0);
    tick(3);
    mode = 1'b0;
    tick(4);
    cnt_in = 4'd15;
    tick(4);
    chk("dnwrap_cnt", cnt_q, 15); chk("dnwrap_ext", ext_q, 0); chk("dnwrap_pulse", wrap_dn, 1);
    tick(1);
    chk("dnwrap_pulse_end", wrap_dn, 0);
    tick(3);
    for (int v = 14; v >= 0; v--) step(4'(v));
    chk("dn_0", cnt_q, 0); chk("dn_0_ext", ext_q, 0);
    cnt_in = 4'd15;
    tick(4);
    chk("dnwrap2_ext", ext_q, 15); chk("dnwrap2_pulse", wrap_dn, 1);
    tick(4);
    for (int v = 14; v >= 6; v--) step(4'(v));
    chk("dn_6", cnt_q, 6);
    mode = 1'b1;
    tick(4);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      cnt_in = (i % 2 == 0) ? 4'd7 : 4'd6;
      tick(1);
      if (valid) nv++;
    end
    chk("glitch_cnt", cnt_q, 6); chk("glitch_no_upd", nv, 0);
    cnt_in = 4'd7;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (valid) nv++;
    end
    chk("glitch_hold_cnt", cnt_q, 7); chk("glitch_one_upd", nv, 1);
    ready = 1'b0;
    cnt_in = 4'd8;
    tick(4);
    chk("bp1_cnt", cnt_q, 8); chk("bp1_valid", valid, 1); chk("bp1_drop", drop, 0);
    tick(4);
    cnt_in = 4'd9;
    tick(4);
    chk("bp2_cnt", cnt_q, 9); chk("bp2_valid", valid, 1); chk("bp2_drop", drop, 1);
    tick(1);
    chk("bp2_drop_end", drop, 0); chk("bp2_valid_hold", valid, 1);
    tick(3);
    ready = 1'b1;
    tick(1);
    chk("bp_consume", valid, 0);
    ready = 1'b0;
    step(4'd10);
    chk("same_pre_valid", valid, 1);
    cnt_in = 4'd11;
    tick(3);
    ready = 1'b1;
    tick(1);
    chk("same_cnt", cnt_q, 11); chk("same_valid", valid, 1); chk("same_nodrop", drop, 0);
    tick(1);
    chk("same_consume", valid, 0);
    chk("legal_no_err", err, 0);
    rst = 1'b0;
    #2;
    chk("midrst_cnt", cnt_q, 0); chk("midrst_ext", ext_q, 0); chk("midrst_valid", valid, 0);
    cnt_in = 4'd2; mode = 1'b1;
    #2;
    rst = 1'b1;
    tick(4);
    chk("reinit_cnt", cnt_q, 2); chk("reinit_valid", valid, 1);
    chk("reinit_nowrap", {wrap_up, wrap_dn}, 0); chk("reinit_err", err, 0);
    tick(4);
    cnt_in = 4'd9;
    tick(4);
    chk("jump_cnt", cnt_q, 9); chk("jump_err", err, CHK);
    tick(5);
    chk("jump_err_sticky", err, CHK);
    rst = 1'b0;
    #1;
    chk("err_cleared", err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
